// File: rtl/branch_predictor_bht.sv
// Direct-mapped 2-bit saturating-counter branch predictor with misprediction flush/redirect.
// Optional performance counters are built when BP_PERF_CNT_EN is defined.
module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int IDX_LSB = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic        upd_is_cond,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        upd_br_taken,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [1:0]       table_q [ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             train;
  logic             mp;
  logic [1:0]       upd_ctr;
  logic [1:0]       ctr_d;
  logic [31:0]      redirect_d;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic             flush_q;
  logic [31:0]      redirect_q;

  // Only the index slice of each PC is consumed; upper bits alias by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc, upd_pc};

  assign fetch_idx = fetch_pc[IDX_LSB +: IDX_W];
  assign upd_idx   = upd_pc[IDX_LSB +: IDX_W];
  assign train     = upd_valid & upd_is_cond;
  assign mp        = upd_valid & (upd_pred_taken != upd_br_taken);
  assign upd_ctr   = table_q[upd_idx];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    ctr_d = upd_ctr;
    if (upd_br_taken) begin
      if (upd_ctr != CTR_ST) ctr_d = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != CTR_SNT) ctr_d = upd_ctr - 2'd1;
    end
    redirect_d = upd_br_taken ? upd_target : (upd_pc + 32'd4);
  end

  // NOTE: the table lives in flops, not RAM, because every entry must reset to weak-NT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_WNT;
    end else if (train) begin
      table_q[upd_idx] <= ctr_d;
    end
  end

  // NOTE: non-blocking assignments keep the lookup reading the pre-update counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= 32'h0;
    end else begin
      pred_valid_q <= fetch_valid;
      if (fetch_valid) pred_taken_q <= table_q[fetch_idx][1];
      flush_q <= mp;
      if (mp) redirect_q <= redirect_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= 32'h0;
      perf_mp_q <= 32'h0;
    end else begin
      if (train) perf_br_q <= perf_br_q + 32'd1;
      if (mp)    perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;
`else
  assign perf_branches = 32'h0;
  assign perf_mispred  = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed vector table, corner-case
// sequences (reset mid-flight, perf counters) and a randomized run against a model.
module tb_branch_predictor_bht;

  localparam int ENTRIES = 64;
  localparam int IDX_LSB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic        upd_is_cond;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        upd_br_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  branch_predictor_bht #(.ENTRIES(ENTRIES), .IDX_LSB(IDX_LSB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_is_cond    (upd_is_cond),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_br_taken   (upd_br_taken),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        uv;
    logic        uc;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        upt;
    logic        ubt;
    logic        pv;
    logic        pt;
    logic        fl;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic uv, input logic uc,
                       input logic [31:0] upc, input logic [31:0] utgt, input logic upt,
                       input logic ubt);
    fetch_valid    = fv;
    fetch_pc       = fpc;
    upd_valid      = uv;
    upd_is_cond    = uc;
    upd_pc         = upc;
    upd_target     = utgt;
    upd_pred_taken = upt;
    upd_br_taken   = ubt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perf_exp(input int v);
`ifdef BP_PERF_CNT_EN
    return 32'(v);
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_perf(input string tag);
    check({tag, ".perf_branches"}, perf_branches, perf_exp(exp_br));
    check({tag, ".perf_mispred"},  perf_mispred,  perf_exp(exp_mp));
  endtask

  function automatic vec_t mk(input logic fv, input logic [31:0] fpc, input logic uv,
                              input logic uc, input logic [31:0] upc, input logic [31:0] utgt,
                              input logic upt, input logic ubt, input logic pv, input logic pt,
                              input logic fl, input logic [31:0] rd);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.uv = uv; v.uc = uc; v.upc = upc; v.utgt = utgt;
    v.upt = upt; v.ubt = ubt; v.pv = pv; v.pt = pt; v.fl = fl; v.rd = rd;
    return v;
  endfunction

  // Behavioural model for the random phase: counters as plain integers 0..3.
  int          m_ctr[ENTRIES];
  logic        m_pt;
  logic [31:0] m_rd;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> IDX_LSB) % ENTRIES);
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
    else pc = (32'($urandom_range(0, 3)) << 30) | (32'($urandom()) & 32'h0000_003C);
    return pc;
  endfunction

  initial begin
    // PCs 0x100/0x200/0x300/0x500 all alias to index 0; 0x40 maps to index 16.
    //          fv    fpc         uv    uc    upc           utgt        upt   ubt   pv    pt    fl    rd
    vecs[0]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h300, 1'b1, 1'b0, 32'h300,      32'h800,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h800);
    vecs[2]  = mk(1'b1, 32'h300, 1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800);
    vecs[3]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h100,      32'h180,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h180);
    vecs[4]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h100,      32'h180,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h180);
    vecs[5]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h100,      32'h180,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h180);
    vecs[6]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h180);
    vecs[7]  = mk(1'b1, 32'h100, 1'b1, 1'b1, 32'h100,      32'h180,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104);
    vecs[8]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h104);
    vecs[9]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200,      32'h900,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h204);
    vecs[10] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h204);
    vecs[11] = mk(1'b1, 32'h40,  1'b1, 1'b1, 32'h40,       32'h80,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h204);
    vecs[12] = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204);
    vecs[13] = mk(1'b1, 32'h100, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1000,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    vecs[14] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h500,      32'hA00,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA00);
    vecs[15] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h500,      32'hA00,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h504);
    vecs[16] = mk(1'b1, 32'h500, 1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h504);

    // Reset values
    rst_n = 1'b0;
    idle();
    #12;
    check("rst.pred_valid", 32'(pred_valid), 32'h0);
    check("rst.pred_taken", 32'(pred_taken), 32'h0);
    check("rst.flush",      32'(flush),      32'h0);
    check("rst.redirect",   redirect_pc,     32'h0);
    check_perf("rst");
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].uv, vecs[i].uc, vecs[i].upc, vecs[i].utgt,
            vecs[i].upt, vecs[i].ubt);
      if (vecs[i].uv && vecs[i].uc) exp_br++;
      if (vecs[i].uv && (vecs[i].upt != vecs[i].ubt)) exp_mp++;
      tick();
      check($sformatf("vec%0d.pred_valid", i), 32'(pred_valid), 32'(vecs[i].pv));
      check($sformatf("vec%0d.pred_taken", i), 32'(pred_taken), 32'(vecs[i].pt));
      check($sformatf("vec%0d.flush", i),      32'(flush),      32'(vecs[i].fl));
      check($sformatf("vec%0d.redirect", i),   redirect_pc,     vecs[i].rd);
      check_perf($sformatf("vec%0d", i));
    end

    // Fresh reset, then 5 conditional updates (2 mispredicted) plus 1 mispredicted jump
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_br = 0;
    exp_mp = 0;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180,  1'b1, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h180,  1'b1, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h2000, 1'b0, 1'b1); tick();
    check("perf_seq.flush_a",    32'(flush), 32'h1);
    check("perf_seq.redirect_a", redirect_pc, 32'h2000);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 32'h3000, 1'b1, 1'b0); tick();
    check("perf_seq.flush_b",    32'(flush), 32'h1);
    check("perf_seq.redirect_b", redirect_pc, 32'h10C);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10C, 32'h4000, 1'b0, 1'b0); tick();
    check("perf_seq.flush_c", 32'(flush), 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h110, 32'h1234, 1'b0, 1'b1); tick();
    check("perf_seq.flush_d",    32'(flush), 32'h1);
    check("perf_seq.redirect_d", redirect_pc, 32'h1234);
    exp_br = 5;
    exp_mp = 3;
    idle();
    tick();
    check_perf("perf_seq");

    // Reset mid-flight: a pending flush and the reset-cycle update must both vanish
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h5555, 1'b0, 1'b1);
    tick();
    check("midrst.pre_flush", 32'(flush), 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h6666, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_br = 0;
    exp_mp = 0;
    check("midrst.flush_async",    32'(flush), 32'h0);
    check("midrst.redirect_async", redirect_pc, 32'h0);
    check_perf("midrst.async");
    tick();
    check("midrst.flush_hold",    32'(flush), 32'h0);
    check("midrst.redirect_hold", redirect_pc, 32'h0);
    idle();
    rst_n = 1'b1;
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("midrst.pred_valid", 32'(pred_valid), 32'h1);
    check("midrst.pred_taken", 32'(pred_taken), 32'h0);
    check_perf("midrst.after");

    // Randomized run against the behavioural model, starting from reset
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    m_pt   = 1'b0;
    m_rd   = 32'h0;
    exp_br = 0;
    exp_mp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic fv, uv, uc, upt, ubt, m_fl;
      logic [31:0] fpc, upc, utgt;
      int k;
      fv   = 1'($urandom_range(0, 1));
      fpc  = rand_pc();
      uv   = ($urandom_range(0, 3) != 0);
      uc   = ($urandom_range(0, 3) != 0);
      upc  = rand_pc();
      utgt = $urandom();
      upt  = 1'($urandom_range(0, 1));
      ubt  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) fpc = upc;
      drive(fv, fpc, uv, uc, upc, utgt, upt, ubt);

      if (fv) m_pt = (m_ctr[idx_of(fpc)] >= 2);
      m_fl = uv && (upt != ubt);
      if (m_fl) begin
        m_rd = ubt ? utgt : upc + 32'd4;
        exp_mp++;
      end
      if (uv && uc) begin
        k = idx_of(upc);
        m_ctr[k] = ubt ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3) : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
        exp_br++;
      end

      tick();
      check($sformatf("rnd%0d.pred_valid", cyc), 32'(pred_valid), 32'(fv));
      check($sformatf("rnd%0d.pred_taken", cyc), 32'(pred_taken), 32'(m_pt));
      check($sformatf("rnd%0d.flush", cyc),      32'(flush),      32'(m_fl));
      check($sformatf("rnd%0d.redirect", cyc),   redirect_pc,     m_rd);
      check_perf($sformatf("rnd%0d", cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Dynamic branch predictor and resolution checker for the RV32 core. A direct-mapped table of 2-bit saturating counters gives a taken/not-taken prediction one cycle after fetch. The block then consumes the resolved `br_taken` from the execute-stage branch comparator to train the table. It flags mispredictions with a registered flush/redirect pulse to the fetch unit.

## Interface
Parameters:
- `ENTRIES`, 64: counter table depth; power of two, 4..1024.
- `IDX_LSB`, 2: lowest PC bit used for indexing. Index is `pc[IDX_LSB +: $clog2(ENTRIES)]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_valid` in 1: a fetch lookup is requested this cycle.
- `fetch_pc` in 32: PC of the fetched instruction.
- `pred_valid` out 1: registered copy of `fetch_valid`.
- `pred_taken` out 1: registered prediction for the previous cycle's `fetch_pc`.
- `upd_valid` in 1: a branch/jump has resolved in execute this cycle.
- `upd_is_cond` in 1: 1 means a conditional branch (br_type 000..101); 0 means unconditional (110/111).
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_target` in 32: computed branch target.
- `upd_pred_taken` in 1: the prediction originally issued for this instruction, carried down the pipe.
- `upd_br_taken` in 1: resolved outcome from the branch comparator.
- `flush` out 1: one-cycle misprediction pulse.
- `redirect_pc` out 32: correct next PC; meaningful while `flush`=1.
- `perf_branches` out 32: resolved conditional branch count.
- `perf_mispred` out 32: misprediction count.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is bit[1].
- Lookup: when `fetch_valid`=1, the counter at the fetch index is registered into `pred_taken`. When `fetch_valid`=0, `pred_taken` holds its value and `pred_valid` goes to 0.
- Training happens only when `upd_valid & upd_is_cond`:
  - If `upd_br_taken`=1, the counter increments and saturates at 11.
  - If `upd_br_taken`=0, the counter decrements and saturates at 00.
  - Unconditional updates never modify the table.
- Mispredict: `mp = upd_valid & (upd_pred_taken != upd_br_taken)`. This applies to both conditional and unconditional instructions.
- Redirect target:
  - `redirect_pc` = `upd_target` if `upd_br_taken`, else `upd_pc + 32'd4`.
  - The addition is 32-bit and wraps modulo 2^32; `upd_pc`=FFFF_FFFC gives 0000_0000.
- `flush` and `redirect_pc` are registered from `mp`. `redirect_pc` updates only on cycles where `mp`=1 and otherwise holds its value.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update counter value (read-before-write). The new value is visible from the next cycle's lookup.
- Back-to-back updates to the same index each apply in order, one step per cycle.
- Upper PC bits are not tagged, so aliasing is permitted.

## Timing
- Reset values (asynchronous, applied while `rst_n`=0):
  - All table entries are 2'b01.
  - `pred_valid`, `pred_taken`, and `flush` are 0.
  - `redirect_pc` and both perf counters are 32'h0.
- Lookup latency: 1 cycle (fetch in cycle N gives `pred_taken` in N+1).
- Update latency: the table write takes effect at the edge ending cycle N. `flush` and `redirect_pc` are asserted during N+1 for exactly one cycle per mispredicting update.
- Consecutive mispredicting updates produce consecutive `flush` pulses, each with its own `redirect_pc`.
- Reset asserted mid-operation clears everything immediately. A pending `flush` is dropped, and no update from the reset cycle is retained.
- There is no back-pressure; every update is accepted every cycle.

## Configuration
- `BP_PERF_CNT_EN` defined:
  - `perf_branches` increments on each `upd_valid & upd_is_cond`.
  - `perf_mispred` increments on each `mp`, whether conditional or not.
  - Both increment registered (visible the next cycle), are 32-bit, and wrap from FFFF_FFFF to 0.
- `BP_PERF_CNT_EN` undefined: the counters are not synthesized, and both ports are tied to 32'h0. The port list is identical in both builds.

## Test plan
- Reset, then look up any PC → `pred_valid`=1 and `pred_taken`=0 (state 01) the next cycle. `flush`=0.
- Three taken conditional updates at PC 0x100 → counter 01→10→11→11. A lookup of 0x100 gives `pred_taken`=1. One not-taken update then gives 10, and the prediction is still 1.
- Conditional update at PC 0x200 with `upd_pred_taken`=1, `upd_br_taken`=0 → next cycle `flush`=1 and `redirect_pc`=0x204 for one cycle only.
- Unconditional update (`upd_is_cond`=0) at 0x300 with target 0x800, `upd_pred_taken`=0, `upd_br_taken`=1 → `flush`=1 and `redirect_pc`=0x800. The counter at the 0x300 index is unchanged at 01.
- Same-cycle lookup and taken update at index of 0x40 (counter 01) → `pred_taken`=0. A lookup the following cycle gives 1.
- With `BP_PERF_CNT_EN`: 5 conditional updates, 2 of them mispredicted, plus 1 mispredicted jump → `perf_branches`=5 and `perf_mispred`=3. Assert `rst_n`=0 mid-sequence → both read 0.
